// File: rtl/f2s_pkg.sv
// Shared types and defaults for the f2s slow-domain event sink.
package f2s_pkg;

  // Default widths for the total-event and pending counters.
  localparam int unsigned F2S_CNT_W  = 16;
  localparam int unsigned F2S_PEND_W = 3;

  // Width of the filter's consecutive-high sample counter (MIN_W up to 255).
  localparam int unsigned F2S_RUN_W  = 8;

  // Edge-filter state encoding.
  typedef logic [1:0] f2s_state_t;
  localparam f2s_state_t F2S_LOW  = 2'd0;
  localparam f2s_state_t F2S_ARM  = 2'd1;
  localparam f2s_state_t F2S_HIGH = 2'd2;

endpackage

// File: rtl/f2s_edge_filter.sv
// Qualifies rising edges of bdat. acc is a single-cycle decision (combinational
// from state and bdat) that the top registers on the same edge.
// Build option: F2S_EVENT_SINK_FILTER_EN adds the ARM state and run_cnt so that
// MIN_W consecutive high samples are needed; otherwise every 0->1 is accepted.
module f2s_edge_filter
  import f2s_pkg::*;
#(
  parameter int unsigned MIN_W = 2
) (
  input  logic bclk,
  input  logic rst,
  input  logic bdat,
  output logic acc
);

  f2s_state_t state_q, state_d;

`ifdef F2S_EVENT_SINK_FILTER_EN
  localparam logic [F2S_RUN_W-1:0] MIN_CNT = F2S_RUN_W'(MIN_W);

  logic [F2S_RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [F2S_RUN_W-1:0] run_inc;

  // State and run counter registers.
  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q   <= F2S_LOW;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next state, run count and accept decision.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    acc       = 1'b0;
    run_inc   = run_cnt_q + F2S_RUN_W'(1);
    case (state_q)
      F2S_LOW: begin
        if (bdat) begin
          run_cnt_d = F2S_RUN_W'(1);
          if (MIN_CNT == F2S_RUN_W'(1)) begin
            acc     = 1'b1;
            state_d = F2S_HIGH;
          end else begin
            state_d = F2S_ARM;
          end
        end
      end
      F2S_ARM: begin
        if (!bdat) begin
          run_cnt_d = '0;
          state_d   = F2S_LOW;
        end else begin
          run_cnt_d = run_inc;
          if (run_inc == MIN_CNT) begin
            acc     = 1'b1;
            state_d = F2S_HIGH;
          end
        end
      end
      F2S_HIGH: begin
        if (!bdat) begin
          run_cnt_d = '0;
          state_d   = F2S_LOW;
        end
      end
      default: begin
        run_cnt_d = '0;
        state_d   = F2S_LOW;
      end
    endcase
  end
`else
  // Without the filter MIN_W only has to be legal; an illegal value disables accepts.
  localparam bit MIN_LEGAL = (MIN_W >= 1) && (MIN_W <= 255);

  // State register.
  always_ff @(posedge bclk) begin
    if (rst) state_q <= F2S_LOW;
    else     state_q <= state_d;
  end

  // Next state and accept decision: LOW/HIGH only.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    case (state_q)
      F2S_LOW: begin
        if (bdat) begin
          acc     = MIN_LEGAL;
          state_d = F2S_HIGH;
        end
      end
      F2S_HIGH: begin
        if (!bdat) state_d = F2S_LOW;
      end
      default: state_d = F2S_LOW;
    endcase
  end
`endif

endmodule

// File: rtl/f2s_event_sink.sv
// Slow-domain event sink: counts qualified bdat rising edges, holds them in a
// saturating pending counter and hands them out over ev_req/ev_ack.
// Build option: F2S_EVENT_SINK_FILTER_EN enables the MIN_W glitch filter.
module f2s_event_sink
  import f2s_pkg::*;
#(
  parameter int unsigned CNT_W  = F2S_CNT_W,
  parameter int unsigned PEND_W = F2S_PEND_W,
  parameter int unsigned MIN_W  = 2
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              bdat,
  input  logic              ev_ack,
  input  logic              ovf_clr,
  output logic              ev_req,
  output logic              evt_pulse,
  output logic [CNT_W-1:0]  evt_total,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] PEND_FULL = '1;

  logic              acc;
  logic              consume;
  logic              pend_full;
  logic              evt_pulse_q, evt_pulse_d;
  logic              ev_req_q, ev_req_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  evt_total_q, evt_total_d;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;

  f2s_edge_filter #(
    .MIN_W (MIN_W)
  ) u_filter (
    .bclk (bclk),
    .rst  (rst),
    .bdat (bdat),
    .acc  (acc)
  );

  // Pending/total/overflow next state; accept and consume together cancel out.
  always_comb begin
    consume     = ev_req_q & ev_ack;
    pend_full   = (pend_cnt_q == PEND_FULL);
    evt_pulse_d = acc;
    evt_total_d = acc ? evt_total_q + CNT_W'(1) : evt_total_q;
    pend_cnt_d  = pend_cnt_q;
    ovf_d       = ovf_q & ~ovf_clr;
    if (acc && !consume) begin
      if (pend_full) ovf_d = 1'b1;
      else           pend_cnt_d = pend_cnt_q + PEND_W'(1);
    end else if (!acc && consume) begin
      pend_cnt_d = pend_cnt_q - PEND_W'(1);
    end
    ev_req_d = (pend_cnt_d != '0);
  end

  // Output registers.
  always_ff @(posedge bclk) begin
    if (rst) begin
      evt_pulse_q <= 1'b0;
      ev_req_q    <= 1'b0;
      ovf_q       <= 1'b0;
      evt_total_q <= '0;
      pend_cnt_q  <= '0;
    end else begin
      evt_pulse_q <= evt_pulse_d;
      ev_req_q    <= ev_req_d;
      ovf_q       <= ovf_d;
      evt_total_q <= evt_total_d;
      pend_cnt_q  <= pend_cnt_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign ev_req    = ev_req_q;
  assign ovf       = ovf_q;
  assign evt_total = evt_total_q;
  assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_f2s_event_sink.sv
// Scoreboard bench for f2s_event_sink (CNT_W=4, PEND_W=3, MIN_W=2).
module tb_f2s_event_sink;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PEND_W = 3;
  localparam int unsigned MIN_W  = 2;
`ifdef F2S_EVENT_SINK_FILTER_EN
  localparam int EFF = 2;
`else
  localparam int EFF = 1;
`endif

  typedef struct {
    int cyc;
    int total;
    int pend;
    int ovf;
  } exp_t;

  logic              bclk = 1'b0;
  logic              rst = 1'b1;
  logic              bdat = 1'b0;
  logic              ev_ack = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              ev_req;
  logic              evt_pulse;
  logic [CNT_W-1:0]  evt_total;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  f2s_event_sink #(
    .CNT_W  (CNT_W),
    .PEND_W (PEND_W),
    .MIN_W  (MIN_W)
  ) dut (
    .bclk      (bclk),
    .rst       (rst),
    .bdat      (bdat),
    .ev_ack    (ev_ack),
    .ovf_clr   (ovf_clr),
    .ev_req    (ev_req),
    .evt_pulse (evt_pulse),
    .evt_total (evt_total),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  // Expected record for a pulse that must be accepted; MIN_W-th sample edge is cyc+EFF.
  task automatic expect_evt(input int total, input int pend, input int o);
    exp_t e;
    e.cyc   = cyc + EFF;
    e.total = total;
    e.pend  = pend;
    e.ovf   = o;
    q.push_back(e);
  endtask

  // High for hi samples then one low sample.
  task automatic pulse(input int hi);
    bdat = 1'b1;
    repeat (hi) step();
    bdat = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Pops one expectation per evt_pulse and compares timing and counters.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge bclk);
      if (evt_pulse === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_evt_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_total_at_pulse", int'(evt_total), e.total);
          chk("pend_at_pulse", int'(pend_cnt), e.pend);
          chk("ovf_at_pulse", int'(ovf), e.ovf);
        end
      end
    end
  endtask

  initial begin
    int pend_tab[8];
    int ovf_tab[8];
    pend_tab = '{1, 2, 3, 4, 5, 6, 7, 7};
    ovf_tab  = '{0, 0, 0, 0, 0, 0, 0, 1};

    fork
      monitor();
    join_none

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_evt_pulse", int'(evt_pulse), 0);
    chk("rst_ev_req", int'(ev_req), 0);
    chk("rst_evt_total", int'(evt_total), 0);
    chk("rst_pend_cnt", int'(pend_cnt), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Clean pulse, high 4 samples, one event only
    expect_evt(1, 1, 0);
    pulse(4);
    step();
    chk("clean_total", int'(evt_total), 1);
    chk("clean_pend", int'(pend_cnt), 1);
    chk("clean_ev_req", int'(ev_req), 1);

    // Single ack drains, stray ack is ignored
    ev_ack = 1'b1;
    step();
    chk("ack_pend", int'(pend_cnt), 0);
    chk("ack_ev_req", int'(ev_req), 0);
    step();
    chk("stray_ack_pend", int'(pend_cnt), 0);
    chk("stray_ack_ev_req", int'(ev_req), 0);
    ev_ack = 1'b0;

    // Overflow: 8 pulses without ack at minimum spacing
    for (int k = 0; k < 8; k++) begin
      expect_evt(k + 2, pend_tab[k], ovf_tab[k]);
      pulse(EFF);
    end
    chk("ovf_pend", int'(pend_cnt), 7);
    chk("ovf_total", int'(evt_total), 9);
    chk("ovf_flag", int'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    chk("ovf_clr_pend", int'(pend_cnt), 7);

    // Accept and consume on the same edge with pend full
    expect_evt(10, 7, 0);
    bdat = 1'b1;
    repeat (EFF - 1) step();
    ev_ack = 1'b1;
    step();
    chk("simul_pend", int'(pend_cnt), 7);
    chk("simul_ovf", int'(ovf), 0);
    bdat = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("drain_pend_%0d", i), int'(pend_cnt), 7 - i);
    end
    chk("drain_ev_req", int'(ev_req), 0);
    ev_ack = 1'b0;
    step();

    // Reset mid-operation with 3 pending and bdat rising
    for (int k = 0; k < 3; k++) begin
      expect_evt(11 + k, k + 1, 0);
      pulse(EFF);
    end
    chk("pre_rst_pend", int'(pend_cnt), 3);
    if (EFF == 1) expect_evt(14, 4, 0);
    bdat = 1'b1;
    step();
    do_reset();
    chk("midrst_evt_pulse", int'(evt_pulse), 0);
    chk("midrst_ev_req", int'(ev_req), 0);
    chk("midrst_total", int'(evt_total), 0);
    chk("midrst_pend", int'(pend_cnt), 0);
    chk("midrst_ovf", int'(ovf), 0);
    expect_evt(1, 1, 0);
    repeat (EFF) step();
    bdat = 1'b0;
    step();
    chk("post_rst_total", int'(evt_total), 1);
    ev_ack = 1'b1;
    step();
    ev_ack = 1'b0;
    chk("post_rst_drain", int'(pend_cnt), 0);

    // Wrap: 17 pulses acked as they arrive
    do_reset();
    ev_ack = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      expect_evt(k % 16, 1, 0);
      pulse(EFF);
    end
    step();
    ev_ack = 1'b0;
    chk("wrap_total", int'(evt_total), 1);
    chk("wrap_pend", int'(pend_cnt), 0);
    chk("wrap_ev_req", int'(ev_req), 0);
    chk("wrap_ovf", int'(ovf), 0);

    // Glitch: one high sample, rejected only when the filter is built
    do_reset();
    if (EFF == 1) expect_evt(1, 1, 0);
    pulse(1);
    repeat (3) step();
    chk("glitch_total", int'(evt_total), (EFF == 1) ? 1 : 0);

    repeat (3) step();
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
